// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one 32-bit asynchronous SRAM between a CPU port and a video refresh
// port. Video fetches have absolute priority and a fixed two-cycle latency
// (request cycle -> one SRAM read cycle -> data). The CPU is stretched with
// cpu_stall until its access completes. A CPU write that is interrupted by
// a video fetch in its strobe cycle is restarted from scratch afterwards.
//
// The block owns all SRAM control strobes. Every strobe and the address,
// write data and byte enables come straight from flops, so the pads see
// clean, glitch-free signals.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   cpu_req      CPU access request; address/data/we/be stable while stalled
//   cpu_we       1 = write, 0 = read
//   cpu_adr      CPU word address
//   cpu_wdata    CPU write data
//   cpu_be       CPU byte enables, active-high
//   cpu_rdata    CPU read data; valid in the ack cycle, held until next read
//   cpu_stall    cpu_req & ~ack (combinational)
//   vid_req      video fetch request, single-cycle pulse
//   vid_adr      video word address, sampled with vid_req
//   vid_data     fetched video word, held until the next fetch completes
//   sram_adr     registered SRAM address
//   sram_dq_out  write data to the pads
//   sram_dq_oe   pad output enable
//   sram_dq_in   read data from the pads
//   sram_ce_n    chip enable, active-low
//   sram_we_n    write enable, active-low
//   sram_be_n    byte enables, active-low
//   steal_cnt    saturating count of video fetches that held off the CPU
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int AW = 18,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_be,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,

  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic [DW-1:0] vid_data,

  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_dq_out,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_in,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic [3:0]    sram_be_n,

  output logic [CW-1:0] steal_cnt
);

  // IDLE : bus parked, chip deselected
  // VRD  : video read cycle, data captured at the end of the cycle
  // CRD  : CPU read cycle, data captured and acked at the end of the cycle
  // CWR1 : CPU write strobe cycle (we_n low)
  // CWR2 : CPU write data-hold cycle (we_n high, bus still driven), acked
  typedef enum logic [2:0] {
    IDLE,
    VRD,
    CRD,
    CWR1,
    CWR2
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t cpu_start;

  // ack is a one-cycle pulse in the cycle after CRD/CWR2. While it is high
  // the still-asserted cpu_req belongs to the access that just finished.
  logic ack;

  // Set when a video fetch preempts CWR1; the write restarts after VRD.
  logic wr_pend;
  logic wr_pend_nxt;

  // CPU has an access waiting that has not been acknowledged yet.
  logic cpu_wait;

  assign cpu_stall = cpu_req & ~ack;

  // -------------------------------------------------------------------------
  // Next-state decision. Video wins from every state; CRD and CWR2 still
  // finish (their completion is captured from the current state below), but
  // an aborted CWR1 is remembered and replayed once the bus is free.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    cpu_wait    = cpu_req & ~ack;
    cpu_start   = IDLE;
    state_nxt   = IDLE;
    wr_pend_nxt = wr_pend;

    if (cpu_wait) begin
      cpu_start = cpu_we ? CWR1 : CRD;
    end

    if (vid_req) begin
      state_nxt = VRD;
      if (state == CWR1) begin
        wr_pend_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE: state_nxt = cpu_start;
        VRD: begin
          if (wr_pend) begin
            state_nxt   = CWR1;
            wr_pend_nxt = 1'b0;
          end else begin
            state_nxt = cpu_start;
          end
        end
        CWR1:    state_nxt = CWR2;
        CRD:     state_nxt = IDLE;
        CWR2:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register, registered SRAM interface and completion capture.
  // Strobes are decoded from the state being entered so they change exactly
  // at the state boundary; an aborted write therefore sees we_n rise on the
  // same edge that starts the video read.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ack         <= 1'b0;
      wr_pend     <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_be_n   <= 4'hF;
      sram_adr    <= '0;
      sram_dq_out <= '0;
      cpu_rdata   <= '0;
      vid_data    <= '0;
      steal_cnt   <= '0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register here samples the values from before the edge.
      state   <= state_nxt;
      wr_pend <= wr_pend_nxt;

      // Completion of the access that occupied the bus this cycle.
      ack <= (state == CRD) || (state == CWR2);
      if (state == VRD) begin
        vid_data <= sram_dq_in;
      end
      if (state == CRD) begin
        cpu_rdata <= sram_dq_in;
      end

      // Moore strobes for the state being entered.
      sram_ce_n  <= (state_nxt == IDLE);
      sram_we_n  <= (state_nxt != CWR1);
      sram_dq_oe <= (state_nxt == CWR1) || (state_nxt == CWR2);

      // Address, data and byte enables load on entry; CWR2 holds the
      // values of CWR1 so the write data stays on the bus.
      case (state_nxt)
        IDLE: begin
          sram_be_n <= 4'hF;
        end
        VRD: begin
          sram_adr  <= vid_adr;
          sram_be_n <= 4'h0;
        end
        CRD: begin
          sram_adr  <= cpu_adr;
          sram_be_n <= 4'h0;
        end
        CWR1: begin
          sram_adr    <= cpu_adr;
          sram_dq_out <= cpu_wdata;
          sram_be_n   <= ~cpu_be;
        end
        default: begin
        end
      endcase

      // Every VRD entry is caused by vid_req; count those that found the
      // CPU waiting, holding at all-ones.
      if (vid_req && cpu_wait && (steal_cnt != {CW{1'b1}})) begin
        steal_cnt <= steal_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM.
// Stimulus pushes expected CPU completions and video words into queues; a
// monitor process pops and compares them when the DUT acks a CPU access or
// when a video word is due two cycles after its request.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_be;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic [DW-1:0] vid_data;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [CW-1:0] steal_cnt;

  sram_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_adr     (cpu_adr),
    .cpu_wdata   (cpu_wdata),
    .cpu_be      (cpu_be),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .vid_req     (vid_req),
    .vid_adr     (vid_adr),
    .vid_data    (vid_data),
    .sram_adr    (sram_adr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_ce_n   (sram_ce_n),
    .sram_we_n   (sram_we_n),
    .sram_be_n   (sram_be_n),
    .steal_cnt   (steal_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read while selected and not driven by
  // the arbiter; byte-masked write sampled at each edge with we_n low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_dq_in = (!sram_ce_n && !sram_dq_oe) ? mem[sram_adr] : '0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          due;      // expected ack cycle, -1 when contention varies
  } cpu_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;      // cycle in which vid_data must hold the word
  } vid_exp_t;

  cpu_exp_t cpu_q[$];
  vid_exp_t vid_q[$];

  int cyc     = 0;
  int err     = 0;
  int chk     = 0;
  int rd_cnt  = 0;   // cycles with a read strobe on the bus
  int wr_cnt  = 0;   // cycles with we_n low
  int last_we = -1;  // last cycle with we_n low

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sram_loop();
    forever begin
      @(posedge clk);
      cyc++;
      if (!sram_ce_n && !sram_we_n) begin
        for (int b = 0; b < 4; b++) begin
          if (!sram_be_n[b]) begin
            mem[sram_adr][8*b +: 8] = sram_dq_out[8*b +: 8];
          end
        end
      end
    end
  endtask

  task automatic monitor_loop();
    cpu_exp_t e;
    vid_exp_t v;
    forever begin
      @(negedge clk);
      if (!sram_ce_n && sram_we_n && !sram_dq_oe) rd_cnt++;
      if (!sram_we_n) begin
        wr_cnt++;
        last_we = cyc;
      end
      if (rst && cpu_req && !cpu_stall) begin
        if (cpu_q.size() == 0) begin
          chk++;
          err++;
          $display("FAIL cpu_unexpected_ack: ack seen with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (e.due >= 0) check("cpu_ack_cycle", 64'(cyc), 64'(e.due));
          if (e.is_read)  check("cpu_rdata", cpu_rdata, e.data);
        end
      end
      while (vid_q.size() > 0 && vid_q[0].due <= cyc) begin
        v = vid_q.pop_front();
        check("vid_data", vid_data, v.data);
      end
    end
  endtask

  task automatic cpu_issue(input logic we, input logic [AW-1:0] adr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp, input int lat,
                           input bit track);
    cpu_exp_t e;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_adr   = adr;
    cpu_wdata = wd;
    cpu_be    = be;
    if (track) begin
      e.is_read = !we;
      e.data    = exp;
      e.due     = (lat < 0) ? -1 : cyc + lat;
      cpu_q.push_back(e);
    end
  endtask

  // Waits for the ack of the outstanding CPU access, then moves on to the
  // next cycle, optionally releasing the request.
  task automatic cpu_wait_done(input bit drop);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (cpu_req && !cpu_stall) done = 1'b1;
    end
    check("cpu_ack_timeout", 64'(done), 64'd1);
    next_cycle();
    if (drop) cpu_req = 1'b0;
  endtask

  task automatic vid_issue(input logic [AW-1:0] adr, input logic [31:0] exp);
    vid_exp_t v;
    vid_req = 1'b1;
    vid_adr = adr;
    v.data  = exp;
    v.due   = cyc + 2;
    vid_q.push_back(v);
  endtask

  initial begin
    int t;
    int c0;

    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_adr   = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    vid_req   = 1'b0;
    vid_adr   = '0;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | i;
    mem['h00100] = 32'h1234_5678;
    mem['h00200] = 32'h1122_3344;
    mem['h00300] = 32'h0000_0000;
    mem['h37FC0] = 32'h0BAD_F00D;
    mem['h37FC1] = 32'hFEED_FACE;

    fork
      sram_loop();
      monitor_loop();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce_n",      64'(sram_ce_n),  64'd1);
    check("rst_we_n",      64'(sram_we_n),  64'd1);
    check("rst_oe",        64'(sram_dq_oe), 64'd0);
    check("rst_be_n",      64'(sram_be_n),  64'hF);
    check("rst_adr",       64'(sram_adr),   64'd0);
    check("rst_cpu_rdata", cpu_rdata,       64'd0);
    check("rst_vid_data",  vid_data,        64'd0);
    check("rst_steal_cnt", 64'(steal_cnt),  64'd0);
    cpu_req = 1'b1;
    #1;
    check("rst_stall_follows_req", 64'(cpu_stall), 64'd1);
    cpu_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Uncontended CPU read: CRD at t+1, ack at t+2, one read strobe
    next_cycle();
    t  = cyc;
    c0 = rd_cnt;
    cpu_issue(1'b0, 'h00100, '0, '0, 32'h1234_5678, 2, 1'b1);
    next_cycle();
    check("rd_sram_adr", 64'(sram_adr),  64'h00100);
    check("rd_ce_n",     64'(sram_ce_n), 64'd0);
    check("rd_stall",    64'(cpu_stall), 64'd1);
    cpu_wait_done(1'b1);
    check("rd_crd_cycles", 64'(rd_cnt - c0), 64'd1);

    // Uncontended partial write: we_n low only in t+1, ack at t+3
    next_cycle();
    t  = cyc;
    c0 = wr_cnt;
    cpu_issue(1'b1, 'h00200, 32'hDEAD_BEEF, 4'b0011, '0, 3, 1'b1);
    cpu_wait_done(1'b1);
    check("wr_we_cycles", 64'(wr_cnt - c0), 64'd1);
    check("wr_we_at",     64'(last_we),     64'(t + 1));
    check("wr_mem_0x200", mem['h00200],     32'h1122_BEEF);

    // Video and CPU read on the same cycle: video first, CPU one cycle late
    next_cycle();
    cpu_issue(1'b0, 'h00100, '0, '0, 32'h1234_5678, 3, 1'b1);
    vid_issue('h37FC0, 32'h0BAD_F00D);
    next_cycle();
    vid_req = 1'b0;
    cpu_wait_done(1'b1);
    check("steal_after_collision", 64'(steal_cnt), 64'd1);

    // Video fetch aborting CWR1: write restarts, ack two cycles late
    next_cycle();
    t = cyc;
    cpu_issue(1'b1, 'h00300, 32'hA5A5_5A5A, 4'hF, '0, 5, 1'b1);
    next_cycle();
    check("abort_in_cwr1", 64'(sram_we_n), 64'd0);
    vid_issue('h37FC1, 32'hFEED_FACE);
    next_cycle();
    vid_req = 1'b0;
    next_cycle();
    check("restart_adr",  64'(sram_adr),  64'h00300);
    check("restart_we_n", 64'(sram_we_n), 64'd0);
    cpu_wait_done(1'b1);
    check("abort_last_we",   64'(last_we),     64'(t + 3));
    check("abort_mem_0x300", mem['h00300],     32'hA5A5_5A5A);
    check("steal_after_abort", 64'(steal_cnt), 64'd2);

    // Continuous video against a stalled CPU read: steal_cnt saturates
    next_cycle();
    cpu_issue(1'b0, 'h00100, '0, '0, 32'h1234_5678, -1, 1'b1);
    vid_req = 1'b1;
    vid_adr = '0;
    for (int k = 1; k <= 70000; k++) begin
      next_cycle();
      if (k == 100)   check("steal_counting", 64'(steal_cnt), 64'd102);
      if (k == 65532) check("steal_below_max", 64'(steal_cnt), 64'hFFFE);
    end
    vid_req = 1'b0;
    check("steal_saturated", 64'(steal_cnt), 64'hFFFF);
    cpu_wait_done(1'b1);
    check("steal_held", 64'(steal_cnt), 64'hFFFF);

    // Back-to-back CPU reads with a video fetch every 16 cycles
    next_cycle();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          cpu_issue(1'b0, AW'('h00400 + i), '0, '0,
                    32'h5A00_0400 + i, -1, 1'b1);
          cpu_wait_done(i == 39);
        end
      end
      begin
        for (int k = 0; k < 8; k++) begin
          vid_issue(AW'('h02000 + k), 32'h5A00_2000 + k);
          next_cycle();
          vid_req = 1'b0;
          repeat (15) next_cycle();
        end
      end
    join

    // Reset asserted in the middle of CWR1
    next_cycle();
    cpu_issue(1'b1, 'h00500, 32'hFFFF_FFFF, 4'hF, '0, -1, 1'b0);
    next_cycle();
    check("pre_rst_we_n", 64'(sram_we_n), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_we_n",  64'(sram_we_n),  64'd1);
    check("midrst_oe",    64'(sram_dq_oe), 64'd0);
    check("midrst_ce_n",  64'(sram_ce_n),  64'd1);
    check("midrst_be_n",  64'(sram_be_n),  64'hF);
    check("midrst_stall", 64'(cpu_stall),  64'd1);
    check("midrst_steal", 64'(steal_cnt),  64'd0);
    cpu_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    repeat (2) next_cycle();
    check("post_rst_idle",  64'(sram_ce_n), 64'd1);
    check("post_rst_mem",   mem['h00500],   32'h5A00_0500);
    check("cpu_q_drained",  64'(cpu_q.size()), 64'd0);
    check("vid_q_drained",  64'(vid_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
